// File: rtl/quan_sa_tile_ctrl.sv
// quan_sa_tile_ctrl
//   Tile sequencer for one 16x16 quantised systolic-array core. Per output tile:
//   CFG (pulse core reset with mode) -> FEED (K accumulate beats, valid/ready)
//   -> SKEW (let the diagonal wavefront settle) -> DRAIN (output_en for one
//   row/column sweep) -> FLUSH (wait out the core output pipeline) -> DONE.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, mode_cfg,      tile request from the layer scheduler; mode/k latched
//   k_len                 on start in IDLE
//   in_valid / in_ready   feeder handshake for accumulate beats
//   sa_reset, sa_mode_init, sa_en, sa_out_en   core control pins
//   out_valid, out_idx    core out bus beat qualifier and beat index
//   busy, done            status to scheduler (done is a 1-cycle pulse)
//
// Optional build macro QUAN_SA_CTRL_PERF_EN adds perf_stall_cnt (FEED cycles
// without a beat, cleared at CFG) and perf_tile_cnt (completed tiles); both
// saturate.
module quan_sa_tile_ctrl #(
  parameter int ROW_NUM  = 16,
  parameter int COL_NUM  = 16,
  parameter int K_CNT_W  = 16,
  parameter int SKEW_LAT = 30,
  parameter int OUT_LAT  = 4,
  parameter int IDX_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         mode_cfg,
  input  logic [K_CNT_W-1:0] k_len,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sa_reset,
  output logic [3:0]         sa_mode_init,
  output logic               sa_en,
  output logic               sa_out_en,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic               busy,
`ifdef QUAN_SA_CTRL_PERF_EN
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_tile_cnt,
`endif
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_FEED, S_SKEW, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  // Phase counter covers SKEW, DRAIN and FLUSH; restarts on every state change.
  localparam int PH_W = 16;
  localparam logic [PH_W-1:0] SKEW_LAST  = PH_W'(SKEW_LAT - 1);
  localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(OUT_LAT - 1);
  localparam logic [PH_W-1:0] COL_LAST   = PH_W'(COL_NUM - 1);
  localparam logic [PH_W-1:0] ROW_LAST   = PH_W'(ROW_NUM - 1);

  state_t             state, state_nxt;
  logic [3:0]         mode_q;
  logic [K_CNT_W-1:0] k_q;
  logic [K_CNT_W-1:0] beat_cnt;
  logic [PH_W-1:0]    ph_cnt;
  logic [PH_W-1:0]    drain_last;
  logic [OUT_LAT-1:0] vld_pipe;
  logic               last_beat;

  // Mode 0 drains columns; every other mode value drains rows.
  assign drain_last = (mode_q == 4'd0) ? COL_LAST : ROW_LAST;
  // Equality against k-1 keeps k = 2^K_CNT_W-1 in range of beat_cnt.
  assign last_beat  = in_valid && (beat_cnt == k_q - K_CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CFG;
      S_CFG:   state_nxt = (k_q == '0) ? S_SKEW : S_FEED;
      S_FEED:  if (last_beat) state_nxt = S_SKEW;
      S_SKEW:  if (ph_cnt == SKEW_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (ph_cnt == drain_last) state_nxt = S_FLUSH;
      S_FLUSH: if (ph_cnt == FLUSH_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    sa_reset  = 1'b0;
    sa_en     = 1'b0;
    sa_out_en = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_CFG:   sa_reset  = 1'b1;
      S_FEED:  begin in_ready = 1'b1; sa_en = in_valid; end
      S_DRAIN: sa_out_en = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  assign sa_mode_init = mode_q;
  assign out_valid    = vld_pipe[OUT_LAT-1];

  // Tile config latch and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= '0;
      k_q      <= '0;
      beat_cnt <= '0;
      ph_cnt   <= '0;
      out_idx  <= '0;
      vld_pipe <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_q <= mode_cfg;
        k_q    <= k_len;
      end
      if (state == S_CFG)                 beat_cnt <= '0;
      else if (state == S_FEED && in_valid) beat_cnt <= beat_cnt + K_CNT_W'(1);

      if (state_nxt != state) ph_cnt <= '0;
      else                    ph_cnt <= ph_cnt + PH_W'(1);

      // out_valid is sa_out_en delayed by OUT_LAT cycles
      vld_pipe <= (vld_pipe << 1) | OUT_LAT'(sa_out_en);

      if (state == S_CFG)  out_idx <= '0;
      else if (out_valid)  out_idx <= out_idx + IDX_W'(1);
    end
  end

`ifdef QUAN_SA_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_tile_cnt  <= '0;
    end else begin
      if (state == S_CFG)
        perf_stall_cnt <= '0;
      else if (state == S_FEED && !in_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (state == S_DONE && perf_tile_cnt != '1)
        perf_tile_cnt <= perf_tile_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quan_sa_tile_ctrl.sv
module tb_quan_sa_tile_ctrl;
  localparam int IDX_W = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mode_cfg = '0;
  logic [15:0] k_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, sa_reset, sa_en, sa_out_en, out_valid, busy, done;
  logic [3:0]  sa_mode_init;
  logic [IDX_W-1:0] out_idx;
`ifdef QUAN_SA_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_tile_cnt;
`endif

  quan_sa_tile_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode_cfg(mode_cfg), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .sa_reset(sa_reset),
    .sa_mode_init(sa_mode_init), .sa_en(sa_en), .sa_out_en(sa_out_en),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy),
`ifdef QUAN_SA_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_tile_cnt(perf_tile_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // per-tile observations, cycle 0 = CFG cycle
  int r_reset_cnt, r_en_cnt, r_en_last, r_ready_last, r_oe_first, r_oe_cnt;
  int r_ov_first, r_ov_cnt, r_idx_err, r_busy_low, r_done_cyc;
  logic [31:0] r_en_mask;
  logic [3:0]  r_mode_seen;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue start from IDLE; returns in the CFG cycle.
  task automatic begin_tile(input logic [3:0] m, input logic [15:0] k);
    start = 1'b1; mode_cfg = m; k_len = k;
    step();
    start = 1'b0;
  endtask

  // Drive feeder pattern (cycle c>=1 gets pat[c-1], then 1s) and record
  // everything until the done cycle; returns still inside the done cycle.
  task automatic run_tile(input int start_at, input logic [31:0] pat, input int plen);
    r_reset_cnt = 0; r_en_cnt = 0; r_en_last = -1; r_ready_last = -1;
    r_oe_first = -1; r_oe_cnt = 0; r_ov_first = -1; r_ov_cnt = 0;
    r_idx_err = 0; r_busy_low = 0; r_done_cyc = -1; r_en_mask = '0; r_mode_seen = '0;
    for (int c = 0; c < 300; c++) begin
      in_valid = (c >= 1) ? ((c - 1 < plen) ? pat[c-1] : 1'b1) : 1'b0;
      start = (c == start_at);
      if (c == start_at) k_len = 16'd100;
      #1;
      if (c == 0) r_mode_seen = sa_mode_init;
      if (sa_reset) r_reset_cnt++;
      if (sa_en) begin
        r_en_cnt++; r_en_last = c;
        if (c < 32) r_en_mask[c] = 1'b1;
      end
      if (in_ready) r_ready_last = c;
      if (sa_out_en) begin
        if (r_oe_cnt == 0) r_oe_first = c;
        r_oe_cnt++;
      end
      if (out_valid) begin
        if (r_ov_cnt == 0) r_ov_first = c;
        if (out_idx !== IDX_W'(r_ov_cnt)) r_idx_err++;
        r_ov_cnt++;
      end
      if (!busy) r_busy_low++;
      if (done) begin r_done_cyc = c; break; end
      step();
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] o;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    o = {in_ready, sa_reset, sa_mode_init, sa_en, sa_out_en, out_valid, out_idx, busy, done};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", o); end
  endtask

  task automatic test_reset_mid_feed();
    int d;
    logic [17:0] o;
    d = 0;
    begin_tile(4'd1, 16'd8);
    in_valid = 1'b1;
    step(); step();
    checks++;
    if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL t1_in_feed got %b exp 11", {busy, in_ready}); end
    reset = 1'b1;
    repeat (3) begin step(); if (done) d++; end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    o = {in_ready, sa_reset, sa_mode_init, sa_en, sa_out_en, out_valid, out_idx, busy, done};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL t1_outputs got %h exp 0", o); end
    step();
    if (done) d++;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t1_stay_idle busy got %b exp 0", busy); end
    checks++;
    if (d !== 0) begin errors++; $display("FAIL t1_no_done got %0d exp 0", d); end
  endtask

  task automatic test_basic_tile();
    begin_tile(4'd0, 16'd8);
    run_tile(-1, 32'hFFFF_FFFF, 32);
    checks++; if (r_reset_cnt !== 1) begin errors++; $display("FAIL t2_reset_cycles got %0d exp 1", r_reset_cnt); end
    checks++; if (r_mode_seen !== 4'd0) begin errors++; $display("FAIL t2_mode got %0d exp 0", r_mode_seen); end
    checks++; if (r_en_mask !== 32'h0000_01FE) begin errors++; $display("FAIL t2_en_mask got %h exp 1fe", r_en_mask); end
    checks++; if (r_en_cnt !== 8) begin errors++; $display("FAIL t2_en_cnt got %0d exp 8", r_en_cnt); end
    checks++; if (r_oe_first !== 39) begin errors++; $display("FAIL t2_oe_first got %0d exp 39", r_oe_first); end
    checks++; if (r_oe_cnt !== 16) begin errors++; $display("FAIL t2_oe_cnt got %0d exp 16", r_oe_cnt); end
    checks++; if (r_ov_first !== 43) begin errors++; $display("FAIL t2_ov_first got %0d exp 43", r_ov_first); end
    checks++; if (r_ov_cnt !== 16) begin errors++; $display("FAIL t2_ov_cnt got %0d exp 16", r_ov_cnt); end
    checks++; if (r_idx_err !== 0) begin errors++; $display("FAIL t2_idx_errs got %0d exp 0", r_idx_err); end
    checks++; if (r_busy_low !== 0) begin errors++; $display("FAIL t2_busy_low got %0d exp 0", r_busy_low); end
    checks++; if (r_done_cyc !== 59) begin errors++; $display("FAIL t2_done_cycle got %0d exp 59", r_done_cyc); end
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL t2_after_done got %b exp 00", {busy, done}); end
  endtask

  task automatic test_stalls();
    begin_tile(4'd1, 16'd5);
    run_tile(-1, 32'h0000_00D9, 8);   // cycles 1..8: 1,0,0,1,1,0,1,1
    checks++; if (r_en_mask !== 32'h0000_01B2) begin errors++; $display("FAIL t3_en_mask got %h exp 1b2", r_en_mask); end
    checks++; if (r_ready_last !== 8) begin errors++; $display("FAIL t3_last_feed got %0d exp 8", r_ready_last); end
    checks++; if (r_oe_first !== 39) begin errors++; $display("FAIL t3_oe_first got %0d exp 39", r_oe_first); end
    checks++; if (r_mode_seen !== 4'd1) begin errors++; $display("FAIL t3_mode got %0d exp 1", r_mode_seen); end
    checks++; if (r_done_cyc !== 59) begin errors++; $display("FAIL t3_done_cycle got %0d exp 59", r_done_cyc); end
    step();
  endtask

  task automatic test_k_zero();
    begin_tile(4'd2, 16'd0);
    run_tile(-1, 32'hFFFF_FFFF, 32);
    checks++; if (r_en_cnt !== 0) begin errors++; $display("FAIL t4_en_cnt got %0d exp 0", r_en_cnt); end
    checks++; if (r_ready_last !== -1) begin errors++; $display("FAIL t4_feed_seen got %0d exp -1", r_ready_last); end
    checks++; if (r_mode_seen !== 4'd2) begin errors++; $display("FAIL t4_mode got %0d exp 2", r_mode_seen); end
    checks++; if (r_oe_first !== 31) begin errors++; $display("FAIL t4_oe_first got %0d exp 31", r_oe_first); end
    checks++; if (r_ov_cnt !== 16) begin errors++; $display("FAIL t4_ov_cnt got %0d exp 16", r_ov_cnt); end
    checks++; if (r_done_cyc !== 51) begin errors++; $display("FAIL t4_done_cycle got %0d exp 51", r_done_cyc); end
    step();
  endtask

  task automatic test_start_ignored();
    begin_tile(4'd0, 16'd2);
    run_tile(1, 32'hFFFF_FFFF, 32);   // start + k_len=100 during FEED
    checks++; if (r_reset_cnt !== 1) begin errors++; $display("FAIL t5_feed_start_reset got %0d exp 1", r_reset_cnt); end
    checks++; if (r_done_cyc !== 53) begin errors++; $display("FAIL t5_done_cycle got %0d exp 53", r_done_cyc); end
    // start in the DONE cycle, held into the following IDLE cycle
    start = 1'b1; mode_cfg = 4'd1; k_len = 16'd3;
    step();
    checks++; if ({busy, sa_reset} !== 2'b00) begin errors++; $display("FAIL t5_done_start got %b exp 00", {busy, sa_reset}); end
    begin_tile(4'd1, 16'd3);
    run_tile(-1, 32'hFFFF_FFFF, 32);
    checks++; if (r_reset_cnt !== 1) begin errors++; $display("FAIL t5_idle_start_reset got %0d exp 1", r_reset_cnt); end
    checks++; if (r_en_cnt !== 3) begin errors++; $display("FAIL t5_en_cnt got %0d exp 3", r_en_cnt); end
    checks++; if (r_done_cyc !== 54) begin errors++; $display("FAIL t5_done_cycle2 got %0d exp 54", r_done_cyc); end
    step();
  endtask

`ifdef QUAN_SA_CTRL_PERF_EN
  task automatic test_perf();
    reset = 1'b1; step(); reset = 1'b0; #1;
    checks++; if ({perf_stall_cnt, perf_tile_cnt} !== 64'd0) begin errors++; $display("FAIL t6_reset got %0d/%0d exp 0/0", perf_stall_cnt, perf_tile_cnt); end
    for (int t = 0; t < 2; t++) begin
      begin_tile(4'd0, 16'd5);
      run_tile(-1, 32'h0000_00D9, 8);
      checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL t6_stall got %0d exp 3", perf_stall_cnt); end
      step();
    end
    checks++; if (perf_tile_cnt !== 32'd2) begin errors++; $display("FAIL t6_tiles got %0d exp 2", perf_tile_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_feed();
    test_basic_tile();
    test_stalls();
    test_k_zero();
    test_start_ignored();
`ifdef QUAN_SA_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
